// File: rtl/id_ex_latch_pkg.sv
// Shared ALU op codes and the control bundle carried from ID into EX.
// The ALU and the ALU-control stage import these same constants.
package id_ex_latch_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0100;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   // A bubble computes a harmless add whose result nobody writes back.
   localparam logic [3:0] BUBBLE_ALUOP = ALU_ADD;

   // Control bits; all of them are 0 in a bubble.
   typedef struct packed {
      logic alu_src;
      logic reg_dst;
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
      logic branch;
   } ex_ctrl_t;

endpackage

// File: rtl/id_ex_latch_sat_counter.sv
// Saturating up-counter: increments on en, sticks at all-ones, never wraps.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] count_d, count_q;

   // Next count: step by one unless already at the ceiling.
   always_comb begin
      count_d = count_q;
      if (en && (count_q != {WIDTH{1'b1}}))
         count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign o_count = count_q;

endmodule

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register: loads decoded fields each stepped cycle, inserts
// bubbles on stall/flush, freezes while step is low, counts bubbles.
module id_ex_latch
   import id_ex_latch_pkg::*;
#(
   parameter int NBITS   = 32,
   parameter int RNBITS  = 5,
   parameter int BOP     = 4,
   parameter int CNTBITS = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_Step,
   input  logic               i_Stall,
   input  logic               i_Flush,
   input  logic               i_Valid,
   input  logic [NBITS-1:0]   i_PC4,
   input  logic [NBITS-1:0]   i_RegA,
   input  logic [NBITS-1:0]   i_RegB,
   input  logic [NBITS-1:0]   i_Imm,
   input  logic [RNBITS-1:0]  i_Shamt,
   input  logic [RNBITS-1:0]  i_Rs,
   input  logic [RNBITS-1:0]  i_Rt,
   input  logic [RNBITS-1:0]  i_Rd,
   input  logic [BOP-1:0]     i_AluOp,
   input  logic               i_AluSrc,
   input  logic               i_RegDst,
   input  logic               i_MemRead,
   input  logic               i_MemWrite,
   input  logic               i_RegWrite,
   input  logic               i_MemToReg,
   input  logic               i_Branch,
   output logic [NBITS-1:0]   o_PC4,
   output logic [NBITS-1:0]   o_RegA,
   output logic [NBITS-1:0]   o_RegB,
   output logic [NBITS-1:0]   o_Imm,
   output logic [RNBITS-1:0]  o_Shamt,
   output logic [RNBITS-1:0]  o_Rs,
   output logic [RNBITS-1:0]  o_Rt,
   output logic [RNBITS-1:0]  o_Rd,
   output logic [BOP-1:0]     o_AluOp,
   output logic               o_AluSrc,
   output logic               o_RegDst,
   output logic               o_MemRead,
   output logic               o_MemWrite,
   output logic               o_RegWrite,
   output logic               o_MemToReg,
   output logic               o_Branch,
   output logic               o_Valid,
   output logic [CNTBITS-1:0] o_BubbleCount
);

   logic [NBITS-1:0]  pc4_d, pc4_q, rega_d, rega_q, regb_d, regb_q, imm_d, imm_q;
   logic [RNBITS-1:0] shamt_d, shamt_q, rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
   logic [BOP-1:0]    aluop_d, aluop_q;
   ex_ctrl_t          ctrl_d, ctrl_q, ctrl_in;
   logic              valid_d, valid_q;
   logic              bubble;

   assign ctrl_in = '{alu_src: i_AluSrc, reg_dst: i_RegDst, mem_read: i_MemRead,
                      mem_write: i_MemWrite, reg_write: i_RegWrite,
                      mem_to_reg: i_MemToReg, branch: i_Branch};

   // Stall and flush collapse into one bubble; ignored while frozen.
   assign bubble = i_Step & (i_Stall | i_Flush);

   // Next state: hold when not stepping, else load, with bubble overrides.
   always_comb begin
      pc4_d   = pc4_q;
      rega_d  = rega_q;
      regb_d  = regb_q;
      imm_d   = imm_q;
      shamt_d = shamt_q;
      rs_d    = rs_q;
      rt_d    = rt_q;
      rd_d    = rd_q;
      aluop_d = aluop_q;
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      if (i_Step) begin
         // Data fields load even in a bubble; EX ignores them then.
         pc4_d   = i_PC4;
         rega_d  = i_RegA;
         regb_d  = i_RegB;
         imm_d   = i_Imm;
         shamt_d = i_Shamt;
         if (bubble) begin
            // Zeroed specifiers keep forwarding/hazard compares from matching.
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            aluop_d = BOP'(BUBBLE_ALUOP);
            ctrl_d  = '0;
            valid_d = 1'b0;
         end else begin
            rs_d    = i_Rs;
            rt_d    = i_Rt;
            rd_d    = i_Rd;
            aluop_d = i_AluOp;
            ctrl_d  = ctrl_in;
            valid_d = i_Valid;
         end
      end
   end

   // Pipeline register; reset leaves a bubble-shaped idle state.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pc4_q   <= '0;
         rega_q  <= '0;
         regb_q  <= '0;
         imm_q   <= '0;
         shamt_q <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         rd_q    <= '0;
         aluop_q <= BOP'(BUBBLE_ALUOP);
         ctrl_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         pc4_q   <= pc4_d;
         rega_q  <= rega_d;
         regb_q  <= regb_d;
         imm_q   <= imm_d;
         shamt_q <= shamt_d;
         rs_q    <= rs_d;
         rt_q    <= rt_d;
         rd_q    <= rd_d;
         aluop_q <= aluop_d;
         ctrl_q  <= ctrl_d;
         valid_q <= valid_d;
      end
   end

   sat_counter #(.WIDTH(CNTBITS)) u_bubble_cnt (
      .clk     (i_clk),
      .rst     (i_reset),
      .en      (bubble),
      .o_count (o_BubbleCount)
   );

   assign o_PC4      = pc4_q;
   assign o_RegA     = rega_q;
   assign o_RegB     = regb_q;
   assign o_Imm      = imm_q;
   assign o_Shamt    = shamt_q;
   assign o_Rs       = rs_q;
   assign o_Rt       = rt_q;
   assign o_Rd       = rd_q;
   assign o_AluOp    = aluop_q;
   assign o_AluSrc   = ctrl_q.alu_src;
   assign o_RegDst   = ctrl_q.reg_dst;
   assign o_MemRead  = ctrl_q.mem_read;
   assign o_MemWrite = ctrl_q.mem_write;
   assign o_RegWrite = ctrl_q.reg_write;
   assign o_MemToReg = ctrl_q.mem_to_reg;
   assign o_Branch   = ctrl_q.branch;
   assign o_Valid    = valid_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: vector table plus reset/saturation sequences.
module tb_id_ex_latch;

   // ctrl order: {alusrc, regdst, memread, memwrite, regwrite, memtoreg, branch}
   typedef struct packed {
      logic [31:0] pc4, a, b, imm;
      logic [4:0]  sh, rs, rt, rd;
      logic [3:0]  op;
      logic [6:0]  ctrl;
      logic        valid;
   } fields_t;

   typedef struct {
      logic    step, stall, flush;
      fields_t in;
      fields_t ex;
      int      cnt;
   } vec_t;

   logic        clk = 1'b0, rst = 1'b1;
   logic        step = 1'b0, stall = 1'b0, flush = 1'b0;
   fields_t     drv = '0, got;
   logic [3:0]  cnt_o;
   int          checks = 0, failures = 0;
   vec_t        v[11];

   always #5 clk = ~clk;

   id_ex_latch #(.NBITS(32), .RNBITS(5), .BOP(4), .CNTBITS(4)) dut (
      .i_clk(clk), .i_reset(rst), .i_Step(step), .i_Stall(stall), .i_Flush(flush),
      .i_Valid(drv.valid), .i_PC4(drv.pc4), .i_RegA(drv.a), .i_RegB(drv.b), .i_Imm(drv.imm),
      .i_Shamt(drv.sh), .i_Rs(drv.rs), .i_Rt(drv.rt), .i_Rd(drv.rd), .i_AluOp(drv.op),
      .i_AluSrc(drv.ctrl[6]), .i_RegDst(drv.ctrl[5]), .i_MemRead(drv.ctrl[4]),
      .i_MemWrite(drv.ctrl[3]), .i_RegWrite(drv.ctrl[2]), .i_MemToReg(drv.ctrl[1]),
      .i_Branch(drv.ctrl[0]),
      .o_PC4(got.pc4), .o_RegA(got.a), .o_RegB(got.b), .o_Imm(got.imm), .o_Shamt(got.sh),
      .o_Rs(got.rs), .o_Rt(got.rt), .o_Rd(got.rd), .o_AluOp(got.op),
      .o_AluSrc(got.ctrl[6]), .o_RegDst(got.ctrl[5]), .o_MemRead(got.ctrl[4]),
      .o_MemWrite(got.ctrl[3]), .o_RegWrite(got.ctrl[2]), .o_MemToReg(got.ctrl[1]),
      .o_Branch(got.ctrl[0]), .o_Valid(got.valid), .o_BubbleCount(cnt_o)
   );

   function automatic fields_t mk(logic [31:0] pc4, a, b, imm, logic [4:0] sh, rs, rt, rd,
                                  logic [3:0] op, logic [6:0] ctrl, logic valid);
      fields_t f;
      f = '{pc4: pc4, a: a, b: b, imm: imm, sh: sh, rs: rs, rt: rt, rd: rd,
            op: op, ctrl: ctrl, valid: valid};
      return f;
   endfunction

   task automatic check(string name, fields_t ex, int cnt);
      checks++;
      if (got !== ex || int'(cnt_o) != cnt) begin
         failures++;
         $display("FAIL %s fields got=%h exp=%h count got=%0d exp=%0d", name, got, ex, cnt_o, cnt);
      end
   endtask

   task automatic apply(logic s, logic st, logic fl, fields_t f);
      @(negedge clk);
      step = s; stall = st; flush = fl; drv = f;
      @(posedge clk); #1;
   endtask

   fields_t rst_state, v0in, v5ex;

   initial begin
      rst_state = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 7'b0, 1'b0);
      v0in = mk(32'h4, 32'h5, 32'h3, 32'h10, 5'd0, 5'd1, 5'd2, 5'd9, 4'b0110, 7'b0000100, 1'b1);
      v5ex = mk(32'h18, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 5'd2, 5'd14, 5'd15, 5'd16,
                4'b1101, 7'b0, 1'b0);

      // normal ALU sub, rd=9
      v[0] = '{1, 0, 0, v0in, v0in, 0};
      // load-use stall with memwrite/rt=4: bubble, data still loads
      v[1] = '{1, 1, 0,
               mk(32'h8, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd3, 5'd3, 5'd4, 5'd0, 4'b0010, 7'b1001000, 1),
               mk(32'h8, 32'h11, 32'h22, 32'hFFFF_FFFC, 5'd3, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0, 0), 1};
      // stall released: normal load
      v[2] = '{1, 0, 0,
               mk(32'hC, 32'h7, 32'h9, 32'h4, 5'd0, 5'd5, 5'd6, 5'd7, 4'b0000, 7'b1010110, 1),
               mk(32'hC, 32'h7, 32'h9, 32'h4, 5'd0, 5'd5, 5'd6, 5'd7, 4'b0000, 7'b1010110, 1), 1};
      // stall and flush together: one bubble
      v[3] = '{1, 1, 1,
               mk(32'h10, 32'h1, 32'h2, 32'h3, 5'd31, 5'd8, 5'd9, 5'd10, 4'b1100, 7'b0100101, 1),
               mk(32'h10, 32'h1, 32'h2, 32'h3, 5'd31, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0, 0), 2};
      // flush of an invalid slot still counts
      v[4] = '{1, 0, 1,
               mk(32'h14, 32'hA, 32'hB, 32'hC, 5'd1, 5'd11, 5'd12, 5'd13, 4'b0111, 7'b0000001, 0),
               mk(32'h14, 32'hA, 32'hB, 32'hC, 5'd1, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0, 0), 3};
      // invalid instruction, normal load: passes through with valid=0
      v[5] = '{1, 0, 0, v5ex, v5ex, 3};
      // three frozen edges with flush/stall and changing inputs
      v[6] = '{0, 0, 1,
               mk(32'h1C, 32'hAAAA, 32'hBBBB, 32'hCCCC, 5'd7, 5'd17, 5'd18, 5'd19, 4'b0110, 7'h7F, 1), v5ex, 3};
      v[7] = '{0, 1, 1,
               mk(32'h20, 32'h1, 32'h1, 32'h1, 5'd8, 5'd20, 5'd21, 5'd22, 4'b0001, 7'h55, 1), v5ex, 3};
      v[8] = '{0, 0, 1,
               mk(32'h24, 32'h99, 32'h77, 32'h55, 5'd9, 5'd23, 5'd24, 5'd25, 4'b0011, 7'h2A, 1), v5ex, 3};
      // step raised with flush still high: bubble of current inputs
      v[9] = '{1, 0, 1,
               mk(32'h24, 32'h99, 32'h77, 32'h55, 5'd9, 5'd23, 5'd24, 5'd25, 4'b0011, 7'h2A, 1),
               mk(32'h24, 32'h99, 32'h77, 32'h55, 5'd9, 5'd0, 5'd0, 5'd0, 4'b0010, 7'b0, 0), 4};
      // normal load with all controls set
      v[10] = '{1, 0, 0,
                mk(32'h28, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 5'd31, 5'd31, 5'd31, 4'b1101, 7'h7F, 1),
                mk(32'h28, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 5'd31, 5'd31, 5'd31, 5'd31, 4'b1101, 7'h7F, 1), 4};

      // Reset held across a couple of edges, released away from the clock edge.
      repeat (2) @(posedge clk);
      #1 check("reset_state", rst_state, 0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 11; i++)
         begin
            apply(v[i].step, v[i].stall, v[i].flush, v[i].in);
            check($sformatf("vec%0d", i), v[i].ex, v[i].cnt);
         end

      // Saturation: 20 stall edges from count 4 must stop at 15.
      for (int k = 1; k <= 20; k++) begin
         apply(1, 1, 0, v0in);
         checks++;
         if (int'(cnt_o) != ((4 + k > 15) ? 15 : 4 + k)) begin
            failures++;
            $display("FAIL sat%0d count got=%0d exp=%0d", k, cnt_o, (4 + k > 15) ? 15 : 4 + k);
         end
      end

      // Load real data, then assert reset mid-cycle: outputs clear at once.
      apply(1, 0, 0, v0in);
      check("preload", v0in, 15);
      #2 rst = 1'b1;
      #1 check("async_reset", rst_state, 0);
      @(negedge clk) rst = 1'b0;
      apply(1, 0, 0, v[2].in);
      check("post_reset_load", v[2].ex, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
